// File: rtl/ram_ctrl_pkg.sv
// Shared types and widths for the ram_ctrl line memory controller.
package ram_ctrl_pkg;

    localparam int unsigned LINE_W = 128;
    localparam int unsigned ADDR_W = 25;

    typedef enum logic [1:0] {INIT, IDLE, BUSY, DONE} state_e;

    typedef enum logic {PORT_INST, PORT_DATA} port_e;

endpackage

// File: rtl/ram_ctrl_mem.sv
// Single-port synchronous line store: one read or one write per enabled cycle.
// The contents are deliberately not reset.
module ram_ctrl_mem
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned LINES_LOG2 = 12
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [LINES_LOG2-1:0] addr,
    input  logic [LINE_W-1:0]     wdata,
    output logic [LINE_W-1:0]     rdata
);

    logic [LINE_W-1:0] mem_q [2**LINES_LOG2];
    logic [LINE_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem_q[addr] <= wdata;
            end else begin
                rdata_q <= mem_q[addr];
            end
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/ram_ctrl.sv
// Line memory controller arbitrating instruction and data ports onto one line store.
// Define RAM_CTRL_TIMEOUT_EN to enable unmapped-address detection and timeout outputs.
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int unsigned LINES_LOG2  = 12,
    parameter int unsigned LATENCY     = 4,
    parameter int unsigned TIMEOUT     = 16,
    parameter int unsigned INIT_CYCLES = 32
) (
    input  logic              clk,
    input  logic              clk_ok,
    input  logic              inst_stb,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [LINE_W-1:0] inst_dout,
    output logic              inst_ack,
    output logic              inst_timeout,
    input  logic              data_stb,
    input  logic              data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [LINE_W-1:0] data_din,
    output logic [LINE_W-1:0] data_dout,
    output logic              data_ack,
    output logic              data_timeout
);

    localparam int unsigned CNT_MAX = (LATENCY > TIMEOUT) ? LATENCY : TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned INIT_W  = $clog2(INIT_CYCLES + 1);

    state_e              state_q, state_d;
    logic [INIT_W-1:0]   init_cnt_q, init_cnt_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    port_e               port_q, port_d;
    logic                we_q, we_d;
    logic                mapped_q, mapped_d;
    logic                inst_ack_q, inst_ack_d, data_ack_q, data_ack_d;
    logic                inst_to_q, inst_to_d, data_to_q, data_to_d;
    logic [LINE_W-1:0]   inst_dout_q, inst_dout_d, data_dout_q, data_dout_d;

    logic                  inst_mapped, data_mapped;
    logic                  mem_en, mem_we;
    logic [LINES_LOG2-1:0] mem_addr;
    logic [LINE_W-1:0]     mem_rdata;

`ifdef RAM_CTRL_TIMEOUT_EN
    assign inst_mapped = (inst_addr[ADDR_W-1:LINES_LOG2] == '0);
    assign data_mapped = (data_addr[ADDR_W-1:LINES_LOG2] == '0);
`else
    // Upper address bits are dropped, so unmapped lines alias onto the store.
    logic unused_addr_hi;
    assign unused_addr_hi = ^{inst_addr[ADDR_W-1:LINES_LOG2], data_addr[ADDR_W-1:LINES_LOG2]};
    assign inst_mapped = 1'b1;
    assign data_mapped = 1'b1;
`endif

    ram_ctrl_mem #(
        .LINES_LOG2 (LINES_LOG2)
    ) u_mem (
        .clk   (clk),
        .en    (mem_en),
        .we    (mem_we),
        .addr  (mem_addr),
        .wdata (data_din),
        .rdata (mem_rdata)
    );

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        cnt_d       = cnt_q;
        port_d      = port_q;
        we_d        = we_q;
        mapped_d    = mapped_q;
        inst_ack_d  = 1'b0;
        data_ack_d  = 1'b0;
        inst_to_d   = 1'b0;
        data_to_d   = 1'b0;
        inst_dout_d = inst_dout_q;
        data_dout_d = data_dout_q;
        mem_en      = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = data_addr[LINES_LOG2-1:0];

        unique case (state_q)
            INIT: begin
                if (init_cnt_q == INIT_W'(INIT_CYCLES - 1)) begin
                    state_d = IDLE;
                end else begin
                    init_cnt_d = init_cnt_q + INIT_W'(1);
                end
            end
            IDLE: begin
                // Data port has priority; a held inst strobe is taken on a later IDLE.
                if (data_stb) begin
                    port_d   = PORT_DATA;
                    we_d     = data_we;
                    mapped_d = data_mapped;
                    mem_en   = data_mapped;
                    mem_we   = data_we;
                    mem_addr = data_addr[LINES_LOG2-1:0];
                    cnt_d    = data_mapped ? CNT_W'(LATENCY - 1) : CNT_W'(TIMEOUT - 1);
                    state_d  = BUSY;
                end else if (inst_stb) begin
                    port_d   = PORT_INST;
                    we_d     = 1'b0;
                    mapped_d = inst_mapped;
                    mem_en   = inst_mapped;
                    mem_addr = inst_addr[LINES_LOG2-1:0];
                    cnt_d    = inst_mapped ? CNT_W'(LATENCY - 1) : CNT_W'(TIMEOUT - 1);
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (port_q == PORT_DATA) begin
                        data_ack_d = mapped_q;
                        data_to_d  = !mapped_q;
                        if (mapped_q && !we_q) data_dout_d = mem_rdata;
                    end else begin
                        inst_ack_d = mapped_q;
                        inst_to_d  = !mapped_q;
                        if (mapped_q) inst_dout_d = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk or negedge clk_ok) begin
        if (!clk_ok) begin
            state_q     <= INIT;
            init_cnt_q  <= '0;
            cnt_q       <= '0;
            port_q      <= PORT_INST;
            we_q        <= 1'b0;
            mapped_q    <= 1'b0;
            inst_ack_q  <= 1'b0;
            data_ack_q  <= 1'b0;
            inst_to_q   <= 1'b0;
            data_to_q   <= 1'b0;
            inst_dout_q <= '0;
            data_dout_q <= '0;
        end else begin
            state_q     <= state_d;
            init_cnt_q  <= init_cnt_d;
            cnt_q       <= cnt_d;
            port_q      <= port_d;
            we_q        <= we_d;
            mapped_q    <= mapped_d;
            inst_ack_q  <= inst_ack_d;
            data_ack_q  <= data_ack_d;
            inst_to_q   <= inst_to_d;
            data_to_q   <= data_to_d;
            inst_dout_q <= inst_dout_d;
            data_dout_q <= data_dout_d;
        end
    end

    assign inst_ack  = inst_ack_q;
    assign data_ack  = data_ack_q;
    assign inst_dout = inst_dout_q;
    assign data_dout = data_dout_q;

`ifdef RAM_CTRL_TIMEOUT_EN
    assign inst_timeout = inst_to_q;
    assign data_timeout = data_to_q;
`else
    logic unused_to;
    assign unused_to    = inst_to_q | data_to_q;
    assign inst_timeout = 1'b0;
    assign data_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_ram_ctrl.sv
// Directed self-checking bench for ram_ctrl; follows RAM_CTRL_TIMEOUT_EN for the
// timeout-versus-aliasing step.
module tb_ram_ctrl;
    import ram_ctrl_pkg::*;

    localparam int unsigned LINES_LOG2  = 12;
    localparam int unsigned LATENCY     = 4;
    localparam int unsigned TIMEOUT     = 16;
    localparam int unsigned INIT_CYCLES = 32;
    // Edges counted from the strobe being raised in IDLE (acceptance is edge 1).
    localparam int ACK_EDGE = LATENCY + 1;
    localparam int TO_EDGE  = TIMEOUT + 1;

    localparam logic [LINE_W-1:0] W1 = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    localparam logic [LINE_W-1:0] W2 = 128'hDEAD_BEEF_CAFE_F00D_1357_9BDF_2468_ACE0;
    localparam logic [LINE_W-1:0] W3 = 128'h5A5A_0F0F_A5A5_F0F0_1111_2222_3333_4444;

    logic              clk;
    logic              clk_ok;
    logic              inst_stb;
    logic [ADDR_W-1:0] inst_addr;
    logic [LINE_W-1:0] inst_dout;
    logic              inst_ack;
    logic              inst_timeout;
    logic              data_stb;
    logic              data_we;
    logic [ADDR_W-1:0] data_addr;
    logic [LINE_W-1:0] data_din;
    logic [LINE_W-1:0] data_dout;
    logic              data_ack;
    logic              data_timeout;

    int checks   = 0;
    int failures = 0;

    ram_ctrl #(
        .LINES_LOG2  (LINES_LOG2),
        .LATENCY     (LATENCY),
        .TIMEOUT     (TIMEOUT),
        .INIT_CYCLES (INIT_CYCLES)
    ) dut (
        .clk          (clk),
        .clk_ok       (clk_ok),
        .inst_stb     (inst_stb),
        .inst_addr    (inst_addr),
        .inst_dout    (inst_dout),
        .inst_ack     (inst_ack),
        .inst_timeout (inst_timeout),
        .data_stb     (data_stb),
        .data_we      (data_we),
        .data_addr    (data_addr),
        .data_din     (data_din),
        .data_dout    (data_dout),
        .data_ack     (data_ack),
        .data_timeout (data_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_line(input string tag, input logic [LINE_W-1:0] obs,
                            input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Raise one strobe from IDLE, wait (bounded) for its ack/timeout, then drop it
    // and step through the dead cycle, checking the completion pulse has ended.
    task automatic req(input bit is_data, input bit we, input logic [ADDR_W-1:0] addr,
                       input logic [LINE_W-1:0] din, output int lat, output bit acked,
                       output bit timed);
        lat   = 0;
        acked = 1'b0;
        timed = 1'b0;
        if (is_data) begin
            data_we   = we;
            data_addr = addr;
            data_din  = din;
            data_stb  = 1'b1;
        end else begin
            inst_addr = addr;
            inst_stb  = 1'b1;
        end
        for (int k = 1; k <= 60; k++) begin
            step();
            if (is_data ? (data_ack | data_timeout) : (inst_ack | inst_timeout)) begin
                lat   = k;
                acked = is_data ? data_ack : inst_ack;
                timed = is_data ? data_timeout : inst_timeout;
                break;
            end
        end
        data_stb = 1'b0;
        inst_stb = 1'b0;
        step();
        chk_bit("pulse_one_cycle", is_data ? (data_ack | data_timeout)
                                           : (inst_ack | inst_timeout), 1'b0);
    endtask

    int lat;
    bit acked;
    bit timed;
    int d_edge;
    int i_edge;
    bit stale;

    initial begin
        clk_ok    = 1'b0;
        inst_stb  = 1'b0;
        inst_addr = '0;
        data_stb  = 1'b0;
        data_we   = 1'b0;
        data_addr = '0;
        data_din  = '0;
        repeat (3) step();

        chk_bit("rst_inst_ack", inst_ack, 1'b0);
        chk_bit("rst_data_ack", data_ack, 1'b0);
        chk_bit("rst_inst_timeout", inst_timeout, 1'b0);
        chk_bit("rst_data_timeout", data_timeout, 1'b0);
        chk_line("rst_inst_dout", inst_dout, '0);
        chk_line("rst_data_dout", data_dout, '0);

        // Init hold: strobe already up at release; first acceptance after INIT.
        data_stb = 1'b1;
        clk_ok   = 1'b1;
        d_edge   = 0;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (data_ack) begin
                d_edge = k;
                break;
            end
        end
        chk_int("init_hold_ack_edge", d_edge, INIT_CYCLES + 1 + LATENCY);
        data_stb = 1'b0;
        step();
        chk_bit("init_ack_one_cycle", data_ack, 1'b0);

        // Write then read back on both ports.
        req(1'b1, 1'b1, 25'd5, W1, lat, acked, timed);
        chk_int("wr5_latency", lat, ACK_EDGE);
        chk_bit("wr5_ack", acked, 1'b1);
        chk_bit("wr5_timeout", timed, 1'b0);

        req(1'b1, 1'b0, 25'd5, '0, lat, acked, timed);
        chk_int("rd5_data_latency", lat, ACK_EDGE);
        chk_line("rd5_data_dout", data_dout, W1);

        req(1'b0, 1'b0, 25'd5, '0, lat, acked, timed);
        chk_int("rd5_inst_latency", lat, ACK_EDGE);
        chk_bit("rd5_inst_ack", acked, 1'b1);
        chk_line("rd5_inst_dout", inst_dout, W1);

        // A write leaves both read registers alone.
        req(1'b1, 1'b1, 25'd7, W2, lat, acked, timed);
        chk_bit("wr7_ack", acked, 1'b1);
        chk_line("wr7_inst_dout_kept", inst_dout, W1);
        chk_line("wr7_data_dout_kept", data_dout, W1);

        // Arbitration: data first, inst LATENCY+2 edges after data's ack.
        data_we   = 1'b0;
        data_addr = 25'd5;
        inst_addr = 25'd7;
        data_stb  = 1'b1;
        inst_stb  = 1'b1;
        d_edge    = 0;
        i_edge    = 0;
        for (int k = 1; k <= 60; k++) begin
            step();
            if (data_ack && d_edge == 0) begin
                d_edge   = k;
                data_stb = 1'b0;
            end
            if (inst_ack && i_edge == 0) begin
                i_edge   = k;
                inst_stb = 1'b0;
                break;
            end
        end
        data_stb = 1'b0;
        inst_stb = 1'b0;
        step();
        chk_int("arb_data_edge", d_edge, ACK_EDGE);
        chk_int("arb_inst_edge", i_edge, ACK_EDGE + LATENCY + 2);
        chk_line("arb_inst_dout", inst_dout, W2);
        chk_line("arb_data_dout", data_dout, W1);

`ifdef RAM_CTRL_TIMEOUT_EN
        req(1'b1, 1'b0, 25'h1FF_FFFF, '0, lat, acked, timed);
        chk_int("to_latency", lat, TO_EDGE);
        chk_bit("to_timeout", timed, 1'b1);
        chk_bit("to_no_ack", acked, 1'b0);
        chk_line("to_dout_kept", data_dout, W1);
`else
        req(1'b1, 1'b1, 25'h1000, W3, lat, acked, timed);
        chk_bit("alias_wr_ack", acked, 1'b1);
        req(1'b1, 1'b0, 25'd0, '0, lat, acked, timed);
        chk_int("alias_rd_latency", lat, ACK_EDGE);
        chk_bit("alias_rd_ack", acked, 1'b1);
        chk_bit("alias_rd_timeout", timed, 1'b0);
        chk_line("alias_rd_dout", data_dout, W3);
`endif

        // Reset in the middle of a read: outputs clear at once, no stale completion.
        data_we   = 1'b0;
        data_addr = 25'd7;
        data_stb  = 1'b1;
        step();
        step();
        #2;
        clk_ok = 1'b0;
        #1;
        chk_line("midrst_data_dout", data_dout, '0);
        chk_line("midrst_inst_dout", inst_dout, '0);
        chk_bit("midrst_data_ack", data_ack, 1'b0);
        data_stb = 1'b0;
        step();
        clk_ok = 1'b1;
        stale  = 1'b0;
        for (int k = 0; k < int'(INIT_CYCLES + LATENCY + 4); k++) begin
            step();
            if (data_ack | inst_ack | data_timeout | inst_timeout) stale = 1'b1;
        end
        chk_bit("midrst_no_stale", stale, 1'b0);

        req(1'b1, 1'b0, 25'd7, '0, lat, acked, timed);
        chk_int("post_rst_latency", lat, ACK_EDGE);
        chk_line("post_rst_dout", data_dout, W2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
